add_seq_ctrl: RTL and testbench



---
 rtl/add_seq_ctrl_if.sv | 38 +++
 rtl/add_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_add_seq_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_ctrl_if.sv
// Operand/result handshake bundle for add_seq_ctrl.
// Carries the ovf flag only when ADD_SEQ_OVF_EN is defined.
interface add_seq_ctrl_if #(
  parameter int unsigned SLICE_W    = 3,
  parameter int unsigned NUM_SLICES = 4
);
  localparam int unsigned OP_W = SLICE_W * NUM_SLICES;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] sum;
  logic            cout;
  logic            busy;
`ifdef ADD_SEQ_OVF_EN
  logic            ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef ADD_SEQ_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef ADD_SEQ_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Wide adder sequenced over one shared SLICE_W-bit ripple-carry slice, LSB chunk first.
// Optional signed-overflow output enabled by defining ADD_SEQ_OVF_EN.
module full_add (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module add_seq_ctrl #(
  parameter int unsigned SLICE_W    = 3,
  parameter int unsigned NUM_SLICES = 4
) (
  input logic          clk,
  input logic          rst_n,
  add_seq_ctrl_if.slave bus
);
  localparam int unsigned OP_W  = SLICE_W * NUM_SLICES;
  localparam int unsigned IDX_W = $clog2(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic [OP_W-1:0] op_a_q, op_a_d;
  logic [OP_W-1:0] op_b_q, op_b_d;
  logic [OP_W-1:0] sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [31:0]        base;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic [SLICE_W:0]   sl_c;

  assign base = 32'(idx_q) * SLICE_W;
  assign sl_a = op_a_q[base +: SLICE_W];
  assign sl_b = op_b_q[base +: SLICE_W];
  assign sl_c[0] = carry_q;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_slice
    full_add u_fa (
      .a_i (sl_a[i]),
      .b_i (sl_b[i]),
      .c_i (sl_c[i]),
      .s_o (sl_s[i]),
      .c_o (sl_c[i+1])
    );
  end

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    idx_d      = idx_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          op_a_d     = bus.a;
          op_b_d     = bus.b;
          carry_d    = bus.cin;
          sum_d      = '0;
          idx_d      = '0;
          ovf_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d[base +: SLICE_W] = sl_s;
        carry_d                = sl_c[SLICE_W];
        if (idx_q == LAST_IDX) begin
          cout_d  = sl_c[SLICE_W];
          // carry into the slice MSB is the carry into operand bit OP_W-1 here
          ovf_d   = sl_c[SLICE_W] ^ sl_c[SLICE_W-1];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      idx_q      <= idx_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef ADD_SEQ_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl at default parameters (12-bit operands, 3-bit slice).
module tb_add_seq_ctrl;
  localparam int unsigned SW   = 3;
  localparam int unsigned NS   = 4;
  localparam int unsigned OP_W = SW * NS;

  typedef struct {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            cin;
    logic [OP_W-1:0] s;
    logic            co;
    logic            ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  vec_t sb[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  add_seq_ctrl_if #(.SLICE_W(SW), .NUM_SLICES(NS)) bus ();
  add_seq_ctrl #(.SLICE_W(SW), .NUM_SLICES(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic cin);
    vec_t v;
    logic [OP_W:0] full;
    full  = {1'b0, a} + {1'b0, b} + {{OP_W{1'b0}}, cin};
    v.a   = a;
    v.b   = b;
    v.cin = cin;
    v.s   = full[OP_W-1:0];
    v.co  = full[OP_W];
    v.ov  = (a[OP_W-1] == b[OP_W-1]) && (full[OP_W-1] != a[OP_W-1]);
    return v;
  endfunction

  // Present operands, wait for acceptance, and queue the expected result.
  task automatic start_op(input vec_t v);
    int n;
    n = 0;
    bus.a = v.a;
    bus.b = v.b;
    bus.cin = v.cin;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb.push_back(v);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic compare_out(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_sum"}, 32'(bus.sum), 32'(e.s));
      check({tag, "_cout"}, 32'(bus.cout), 32'(e.co));
`ifdef ADD_SEQ_OVF_EN
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ov));
`endif
    end
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_hs_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_hs_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_hs_busy"}, 32'(bus.busy), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, acc, ovcnt;
    logic prev;
    vec_t v;

    tbl[0] = '{a: 12'hFFF, b: 12'h001, cin: 1'b0, s: 12'h000, co: 1'b1, ov: 1'b0};
    tbl[1] = '{a: 12'h123, b: 12'h456, cin: 1'b1, s: 12'h57A, co: 1'b0, ov: 1'b0};
    tbl[2] = '{a: 12'h0F0, b: 12'h00F, cin: 1'b0, s: 12'h0FF, co: 1'b0, ov: 1'b0};
    tbl[3] = '{a: 12'h800, b: 12'h800, cin: 1'b0, s: 12'h000, co: 1'b1, ov: 1'b1};
    tbl[4] = '{a: 12'h7FF, b: 12'h001, cin: 1'b0, s: 12'h800, co: 1'b0, ov: 1'b1};
    tbl[5] = '{a: 12'h001, b: 12'h001, cin: 1'b0, s: 12'h002, co: 1'b0, ov: 1'b0};
    for (int i = 6; i < 10; i++)
      tbl[i] = model(OP_W'($urandom), OP_W'($urandom), 1'($urandom));

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b0;
    #23;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      start_op(tbl[i]);
      wait_out(cyc);
      check($sformatf("vec%0d_latency", i), 32'(cyc), 32'd4);
      compare_out($sformatf("vec%0d", i));
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure: result held, new request ignored.
    start_op(tbl[1]);
    wait_out(cyc);
    compare_out("bp");
    bus.a = 12'hAAA;
    bus.b = 12'h555;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("bp_sum_hold", 32'(bus.sum), 32'h57A);
      check("bp_cout_hold", 32'(bus.cout), 32'd0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    handshake("bp");

    // Back-to-back with out_ready tied high.
    bus.out_ready = 1'b1;
    start_op(tbl[2]);
    v = tbl[3];
    bus.a = v.a;
    bus.b = v.b;
    bus.cin = v.cin;
    bus.in_valid = 1'b1;
    sb.push_back(v);
    prev = 1'b1;
    acc = 0;
    ovcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        ovcnt++;
        check("b2b_first_latency", 32'(k), 32'd4);
        compare_out("b2b_first");
      end
      if (bus.busy && !prev) begin
        acc = k;
        break;
      end
      prev = bus.busy;
    end
    bus.in_valid = 1'b0;
    check("b2b_accept_spacing", 32'(acc), 32'd6);
    check("b2b_pulse_width", 32'(ovcnt), 32'd1);
    wait_out(cyc);
    check("b2b_second_latency", 32'(cyc), 32'd4);
    compare_out("b2b_second");
    @(posedge clk); #1;
    check("b2b_pulse_end", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Reset in the middle of RUN discards the operation.
    start_op(model(12'hFFF, 12'hFFF, 1'b1));
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    check("mid_rst_cout", 32'(bus.cout), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rel_in_ready", 32'(bus.in_ready), 32'd1);
    start_op(tbl[5]);
    wait_out(cyc);
    check("post_rst_latency", 32'(cyc), 32'd4);
    compare_out("post_rst");
    handshake("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
